// File: rtl/spi_norflash_slave.sv
// rtl/spi_norflash_slave.sv - byte-wide SPI NOR flash target with a small word array
module spi_norflash_slave #(
    parameter int SPIW  = 8,
    parameter int DATAW = 32,
    parameter int DEPTH = 16
) (
    input  logic            p_clk,
    input  logic            p_reset_n,
    input  logic            s_clk,
    input  logic            s_css,
    input  logic [SPIW-1:0] s_mosi,
    output logic [SPIW-1:0] s_miso,
    output logic            wel,
    output logic            prog_done,
    output logic            frame_abort
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [7:0] OP_READ = 8'h01;
    localparam logic [7:0] OP_PROG = 8'h02;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        STAT,
        IGNORE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    // Only the word-index bits of the 24-bit address influence behaviour.
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATAW-1:0]  shift_q, shift_d;
    logic [SPIW-1:0]   s_miso_q, s_miso_d;
    logic              wel_q, wel_d;
    logic              prog_done_q, prog_done_d;
    logic              frame_abort_q, frame_abort_d;
    logic              s_clk_q, s_css_q;
    logic [DATAW-1:0]  mem_q [DEPTH];

    logic              rise, css_rise, mem_we;
    logic [AW-1:0]     addr_nxt, idx_inc;
    logic [DATAW-1:0]  shift_nxt;

    assign rise      = s_clk & ~s_clk_q & ~s_css;
    assign css_rise  = s_css & ~s_css_q;
    assign addr_nxt  = AW'({addr_q, s_mosi});
    assign idx_inc   = addr_q + AW'(1);
    assign shift_nxt = DATAW'({shift_q, s_mosi});

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        shift_d       = shift_q;
        s_miso_d      = s_miso_q;
        wel_d         = wel_q;
        prog_done_d   = 1'b0;
        frame_abort_d = 1'b0;
        mem_we        = 1'b0;

        if (s_css) begin
            state_d    = IDLE;
            byte_cnt_d = 2'd0;
            s_miso_d   = '0;
            cmd_d      = 8'h00;
            if (css_rise && cmd_q == OP_PROG) begin
                wel_d = 1'b0;
                if (state_q == DATA && byte_cnt_q != 2'd0) begin
                    frame_abort_d = 1'b1;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        cmd_d   = s_mosi;
                        state_d = CMD;
                        if (s_mosi == OP_RDSR) begin
                            s_miso_d = {{(SPIW-2){1'b0}}, wel_q, 1'b0};
                        end
                    end
                end
                // Decode cycle: a new rise cannot land here, since s_clk was just high.
                CMD: begin
                    byte_cnt_d = 2'd0;
                    case (cmd_q)
                        OP_READ, OP_PROG: state_d = ADDR;
                        OP_RDSR:          state_d = STAT;
                        OP_WREN: begin
                            wel_d   = 1'b1;
                            state_d = IGNORE;
                        end
                        OP_WRDI: begin
                            wel_d   = 1'b0;
                            state_d = IGNORE;
                        end
                        default:          state_d = IGNORE;
                    endcase
                end
                ADDR: begin
                    if (rise) begin
                        addr_d     = addr_nxt;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd2) begin
                            state_d    = DATA;
                            byte_cnt_d = 2'd0;
                            if (cmd_q == OP_READ) begin
                                s_miso_d = mem_q[addr_nxt][DATAW-1 -: SPIW];
                            end
                        end
                    end
                end
                DATA: begin
                    if (rise) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            addr_d = idx_inc;
                        end
                        if (cmd_q == OP_READ) begin
                            case (byte_cnt_q)
                                2'd0:    s_miso_d = mem_q[addr_q][DATAW-1-SPIW   -: SPIW];
                                2'd1:    s_miso_d = mem_q[addr_q][DATAW-1-2*SPIW -: SPIW];
                                2'd2:    s_miso_d = mem_q[addr_q][DATAW-1-3*SPIW -: SPIW];
                                default: s_miso_d = mem_q[idx_inc][DATAW-1 -: SPIW];
                            endcase
                        end else begin
                            shift_d = shift_nxt;
                            if (byte_cnt_q == 2'd3) begin
                                mem_we      = wel_q;
                                prog_done_d = wel_q;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge p_clk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            state_q       <= IDLE;
            byte_cnt_q    <= 2'd0;
            cmd_q         <= 8'h00;
            addr_q        <= '0;
            shift_q       <= '0;
            s_miso_q      <= '0;
            wel_q         <= 1'b0;
            prog_done_q   <= 1'b0;
            frame_abort_q <= 1'b0;
            s_clk_q       <= 1'b0;
            s_css_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            shift_q       <= shift_d;
            s_miso_q      <= s_miso_d;
            wel_q         <= wel_d;
            prog_done_q   <= prog_done_d;
            frame_abort_q <= frame_abort_d;
            s_clk_q       <= s_clk;
            s_css_q       <= s_css;
        end
    end

    always_ff @(posedge p_clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= shift_nxt;
        end
    end

    assign s_miso      = s_miso_q;
    assign wel         = wel_q;
    assign prog_done   = prog_done_q;
    assign frame_abort = frame_abort_q;
endmodule

// File: doc/spi_norflash_slave.md
Name: spi_norflash_slave

Overview:
- Synthesizable byte-wide SPI NOR flash target.
- Sits directly downstream of the APB-to-SPI controller. Consumes its s_clk/s_css/s_mosi and returns s_miso.
- Holds a small 32-bit word array and implements write-enable, program, read and status commands.
- Used as the bench/FPGA flash stand-in for controller bring-up. Runs entirely in the p_clk domain.

Parameters:
- SPIW, 8, byte width of s_mosi/s_miso.
- DATAW, 32, word width (4 bytes, MSB first).
- DEPTH, 16, number of words. Must be a power of two; AW = log2(DEPTH).

Ports:
- p_clk  input  1  system clock; all state updates on its rising edge.
- p_reset_n  input  1  asynchronous active-low reset.
- s_clk  input  1  SPI clock from controller, sampled by p_clk.
- s_css  input  1  chip select, active low.
- s_mosi  input  SPIW  command/address/data byte from controller.
- s_miso  output  SPIW  registered response byte.
- wel  output  1  write-enable latch state.
- prog_done  output  1  one-cycle pulse when a full word is committed to the array.
- frame_abort  output  1  one-cycle pulse when s_css rises with a partial program word pending.

Behaviour:
- Reset (asynchronous, p_reset_n=0):
  - s_miso=0, wel=0, prog_done=0, frame_abort=0.
  - byte_cnt=0, state=IDLE, cmd=0, addr=0.
  - Array contents are not reset. A reset mid-frame discards the frame; no partial writes.
- Edge detect: s_clk_q is s_clk delayed one p_clk. rise = s_clk & ~s_clk_q & ~s_css. One byte is consumed per rise, sampled from s_mosi in that cycle.
- Frame start/end:
  - s_css high forces state=IDLE, byte_cnt=0, s_miso=0.
  - An s_css low→high transition ends the frame.
- States:
  - IDLE → CMD on the first rise with s_css low. That byte latches cmd.
  - CMD → ADDR after a cmd of 0x01 or 0x02.
  - CMD → STAT after 0x05.
  - CMD → IGNORE after 0x06 (sets wel), 0x04 (clears wel), or any unknown opcode.
  - ADDR: 3 bytes latched MSB first into addr[23:0]. Word index = addr[AW-1:0]. After the third byte, go to DATA.
  - DATA read (cmd 0x01): on the third address rise, s_miso <= mem[idx][31:24] on the next cycle. Each following rise presents the next byte: [23:16], [15:8], [7:0].
  - DATA program (cmd 0x02):
    - Bytes are assembled into a 32-bit shift register.
    - On the 4th byte, if wel=1: write mem[idx] and pulse prog_done the following cycle.
    - If wel=0, the word is dropped silently.
  - Burst: after every 4 data bytes, idx increments modulo DEPTH (DEPTH-1 wraps to 0). Reads continue with the next word's MSB; programs continue accumulating.
  - STAT: s_miso = {6'b0, wel, 1'b0} from the cycle after the cmd rise, held while s_css is low.
  - IGNORE: bytes are consumed with no effect.
- wel clears on the s_css rise that ends any 0x02 frame, whether or not data was written.
- frame_abort pulses if s_css rises while the program byte count mod 4 != 0. That partial word is discarded.
- Read and program never occur in one frame. Simultaneous rise and s_css deassert in the same cycle: deassert wins and the byte is ignored.
- s_miso only changes on a rise cycle or on s_css high. Latency is 1 p_clk after rise.

Test Plan:
- Reset pulse low 4–12 ns, then frame 0x05 → s_miso=0x00, wel=0. Frame 0x06, then frame 0x05 → s_miso=0x02.
- Frame 0x06; then frame 0x02,00,00,00,FF,00,FF,00 → prog_done pulses once, mem[0]=0xFF00FF00, wel=0 after s_css rises.
- Frame 0x01,00,00,00 plus 4 dummy bytes → s_miso sequence FF,00,FF,00, each valid 1 p_clk after the rise.
- Without wel: frame 0x02,00,00,01,12,34,56,78 → no prog_done; read of addr 1 returns the prior value.
- Burst program at addr DEPTH-1 (0x00000F) with 8 data bytes AABBCCDD 11223344 → mem[15]=0xAABBCCDD, mem[0]=0x11223344, two prog_done pulses.
- Program frame with wel=1 deasserted after 2 data bytes → frame_abort pulses, mem unchanged. p_reset_n asserted mid-read frame → s_miso=0 immediately and state=IDLE.
